// File: rtl/wb_regfile.sv
// Writeback stage: picks ALU or memory data from the MEM/WB buffer, commits it to the
// register file, drives the output port and offers two bypassed decode read ports.
module wb_regfile #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3,
    parameter int NREGS  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [2:0]        controlSignals_in,
    input  logic [DATA_W-1:0] alu_data_in,
    input  logic [DATA_W-1:0] mem_data_in,
    input  logic [ADDR_W-1:0] write_add_in,
    input  logic [ADDR_W-1:0] rd_add1,
    input  logic [ADDR_W-1:0] rd_add2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    output logic [DATA_W-1:0] out_port,
    output logic              out_valid,
    output logic [15:0]       wb_count
);

    logic              reg_write;
    logic              mem_to_reg;
    logic              out_en;
    logic [DATA_W-1:0] wb_data;
    logic [DATA_W-1:0] regs_reg [NREGS];
    logic [DATA_W-1:0] out_port_reg;
    logic              out_valid_reg;
    logic [15:0]       wb_count_reg;

    assign reg_write  = controlSignals_in[0];
    assign mem_to_reg = controlSignals_in[1];
    assign out_en     = controlSignals_in[2];
    assign wb_data    = mem_to_reg ? mem_data_in : alu_data_in;

    // Registers are flops rather than RAM: reads are combinational and reset clears them all.
    generate
        for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    regs_reg[gi] <= '0;
                end else if (reg_write && (write_add_in == ADDR_W'(gi))) begin
                    regs_reg[gi] <= wb_data;
                end
            end
        end
    endgenerate

    // Same-cycle bypass lets decode see the value being written back this cycle.
    assign rd_data1 = (reg_write && (write_add_in == rd_add1)) ? wb_data : regs_reg[rd_add1];
    assign rd_data2 = (reg_write && (write_add_in == rd_add2)) ? wb_data : regs_reg[rd_add2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_port_reg  <= '0;
            out_valid_reg <= 1'b0;
            wb_count_reg  <= '0;
        end else begin
            out_valid_reg <= out_en;
            if (out_en) begin
                out_port_reg <= wb_data;
            end
            if (reg_write) begin
                wb_count_reg <= wb_count_reg + 16'd1;
            end
        end
    end

    assign out_port  = out_port_reg;
    assign out_valid = out_valid_reg;
    assign wb_count  = wb_count_reg;

endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: directed vector table, reset/wrap sequences and randomized
// traffic checked against an array-based reference model.
module tb_wb_regfile;

    logic        clk;
    logic        rst_n;
    logic [2:0]  ctrl;
    logic [15:0] alu;
    logic [15:0] mem;
    logic [2:0]  wa;
    logic [2:0]  ra1;
    logic [2:0]  ra2;
    logic [15:0] rd1;
    logic [15:0] rd2;
    logic [15:0] out_port;
    logic        out_valid;
    logic [15:0] wb_count;

    int checks = 0;
    int errors = 0;

    wb_regfile #(.DATA_W(16), .ADDR_W(3), .NREGS(8)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .controlSignals_in(ctrl),
        .alu_data_in      (alu),
        .mem_data_in      (mem),
        .write_add_in     (wa),
        .rd_add1          (ra1),
        .rd_add2          (ra2),
        .rd_data1         (rd1),
        .rd_data2         (rd2),
        .out_port         (out_port),
        .out_valid        (out_valid),
        .wb_count         (wb_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain architectural state updated from the behavioural rules.
    logic [15:0] m_regs [8];
    logic [15:0] m_out;
    logic        m_valid;
    logic [15:0] m_cnt;

    function automatic logic [15:0] m_wb();
        return ctrl[1] ? mem : alu;
    endfunction

    function automatic logic [15:0] m_read(input logic [2:0] ra);
        if (ctrl[0] && wa == ra) return m_wb();
        return m_regs[ra];
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 8; i++) m_regs[i] = 16'h0;
        m_out = 16'h0;
        m_valid = 1'b0;
        m_cnt = 16'h0;
    endtask

    task automatic m_edge();
        logic [15:0] wb;
        wb = m_wb();
        if (ctrl[0]) begin
            m_regs[wa] = wb;
            m_cnt = m_cnt + 16'd1;
        end
        m_valid = ctrl[2];
        if (ctrl[2]) m_out = wb;
    endtask

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Advance one clock edge with reset released, model follows the same edge.
    task automatic cycle();
        m_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] c, input logic [15:0] a, input logic [15:0] m,
                         input logic [2:0] w, input logic [2:0] r1, input logic [2:0] r2);
        ctrl = c; alu = a; mem = m; wa = w; ra1 = r1; ra2 = r2;
    endtask

    typedef struct {
        logic [2:0]  ctrl;
        logic [15:0] alu;
        logic [15:0] mem;
        logic [2:0]  wa;
        logic [2:0]  ra1;
        logic [2:0]  ra2;
        logic [15:0] e_rd1;
        logic [15:0] e_rd2;
        logic [15:0] e_out;
        logic        e_val;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vecs [9];

    initial begin
        // Expected values assume a freshly reset register file.
        vecs[0] = '{3'b001, 16'h1234, 16'h0000, 3'd5, 3'd5, 3'd0, 16'h1234, 16'h0000, 16'h0000, 1'b0, 16'd1};
        vecs[1] = '{3'b011, 16'h0001, 16'hBEEF, 3'd3, 3'd3, 3'd3, 16'hBEEF, 16'hBEEF, 16'h0000, 1'b0, 16'd2};
        vecs[2] = '{3'b000, 16'hFFFF, 16'hFFFF, 3'd3, 3'd3, 3'd5, 16'hBEEF, 16'h1234, 16'h0000, 1'b0, 16'd2};
        vecs[3] = '{3'b100, 16'h00A5, 16'h1111, 3'd5, 3'd5, 3'd3, 16'h1234, 16'hBEEF, 16'h00A5, 1'b1, 16'd2};
        vecs[4] = '{3'b000, 16'h0000, 16'h0000, 3'd0, 3'd5, 3'd3, 16'h1234, 16'hBEEF, 16'h00A5, 1'b0, 16'd2};
        vecs[5] = '{3'b110, 16'h2222, 16'h3333, 3'd0, 3'd0, 3'd0, 16'h0000, 16'h0000, 16'h3333, 1'b1, 16'd2};
        vecs[6] = '{3'b101, 16'h7777, 16'h0000, 3'd0, 3'd0, 3'd7, 16'h7777, 16'h0000, 16'h7777, 1'b1, 16'd3};
        vecs[7] = '{3'b111, 16'h0001, 16'hABCD, 3'd7, 3'd0, 3'd7, 16'h7777, 16'hABCD, 16'hABCD, 1'b1, 16'd4};
        vecs[8] = '{3'b000, 16'h0000, 16'h0000, 3'd7, 3'd7, 3'd0, 16'hABCD, 16'h7777, 16'hABCD, 1'b0, 16'd4};

        rst_n = 1'b0;
        drive(3'b000, 16'h0, 16'h0, 3'd0, 3'd0, 3'd0);
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("reset_out_port", out_port, 16'h0);
        chk("reset_out_valid", {15'h0, out_valid}, 16'h0);
        chk("reset_wb_count", wb_count, 16'h0);

        // Directed table
        for (int i = 0; i < 9; i++) begin
            drive(vecs[i].ctrl, vecs[i].alu, vecs[i].mem, vecs[i].wa, vecs[i].ra1, vecs[i].ra2);
            #1;
            chk($sformatf("vec%0d_rd1", i), rd1, vecs[i].e_rd1);
            chk($sformatf("vec%0d_rd2", i), rd2, vecs[i].e_rd2);
            cycle();
            chk($sformatf("vec%0d_out_port", i), out_port, vecs[i].e_out);
            chk($sformatf("vec%0d_out_valid", i), {15'h0, out_valid}, {15'h0, vecs[i].e_val});
            chk($sformatf("vec%0d_wb_count", i), wb_count, vecs[i].e_cnt);
            $display("vec %0d ctrl=%b alu=%h mem=%h wa=%0d rd1=%h rd2=%h out=%h v=%b cnt=%0d",
                     i, vecs[i].ctrl, vecs[i].alu, vecs[i].mem, vecs[i].wa, rd1, rd2,
                     out_port, out_valid, wb_count);
        end

        // Asynchronous mid-cycle reset clears everything at once
        drive(3'b000, 16'h0, 16'h0, 3'd0, 3'd0, 3'd0);
        #1;
        rst_n = 1'b0;
        m_reset();
        #1;
        chk("async_out_port", out_port, 16'h0);
        chk("async_out_valid", {15'h0, out_valid}, 16'h0);
        chk("async_wb_count", wb_count, 16'h0);
        for (int r = 0; r < 8; r++) begin
            ra1 = 3'(r);
            ra2 = 3'(7 - r);
            #1;
            chk($sformatf("async_r%0d_p1", r), rd1, 16'h0);
            chk($sformatf("async_r%0d_p2", 7 - r), rd2, 16'h0);
        end
        $display("seq reset: out=%h v=%b cnt=%0d", out_port, out_valid, wb_count);

        // Write attempted while reset is held must not land
        drive(3'b101, 16'h5555, 16'h0, 3'd2, 3'd2, 3'd2);
        @(posedge clk);
        #1;
        ctrl = 3'b000;
        #1;
        chk("held_reset_reg", rd1, 16'h0);
        chk("held_reset_count", wb_count, 16'h0);
        chk("held_reset_valid", {15'h0, out_valid}, 16'h0);
        $display("seq held reset: rd=%h cnt=%0d", rd1, wb_count);

        // Write presented on the deasserting edge is committed
        @(posedge clk);
        #1;
        drive(3'b001, 16'h5555, 16'h0, 3'd2, 3'd2, 3'd2);
        #5;
        rst_n = 1'b1;
        cycle();
        ctrl = 3'b000;
        #1;
        chk("release_edge_reg", rd1, 16'h5555);
        chk("release_edge_count", wb_count, 16'd1);
        $display("seq release edge: rd=%h cnt=%0d", rd1, wb_count);

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            drive(3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom),
                  3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
            #1;
            chk("rand_rd1", rd1, m_read(ra1));
            chk("rand_rd2", rd2, m_read(ra2));
            cycle();
            chk("rand_out_port", out_port, m_out);
            chk("rand_out_valid", {15'h0, out_valid}, {15'h0, m_valid});
            chk("rand_wb_count", wb_count, m_cnt);
            $display("rand %0d ctrl=%b wa=%0d rd1=%h rd2=%h out=%h v=%b cnt=%0d",
                     n, ctrl, wa, rd1, rd2, out_port, out_valid, wb_count);
        end

        // Counter wrap combined with output port
        ctrl = 3'b000;
        #1;
        rst_n = 1'b0;
        m_reset();
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int n = 0; n < 65535; n++) begin
            drive(3'b001, 16'($urandom), 16'($urandom), 3'($urandom_range(0, 6)), 3'd0, 3'd0);
            cycle();
        end
        chk("preload_count", wb_count, 16'hFFFF);
        drive(3'b101, 16'h7777, 16'h1234, 3'd7, 3'd7, 3'd0);
        cycle();
        ctrl = 3'b000;
        #1;
        chk("wrap_r7", rd1, 16'h7777);
        chk("wrap_out_port", out_port, 16'h7777);
        chk("wrap_out_valid", {15'h0, out_valid}, 16'h1);
        chk("wrap_count", wb_count, 16'h0000);
        cycle();
        chk("wrap_valid_pulse", {15'h0, out_valid}, 16'h0);
        chk("wrap_out_hold", out_port, 16'h7777);
        chk("wrap_count_hold", wb_count, 16'h0000);
        $display("seq wrap: r7=%h out=%h cnt=%h", rd1, out_port, wb_count);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
